// File: rtl/timer_countdown_chain.sv
// Multi-digit countdown timer: cascaded per-digit-radix down counter plus run-control FSM.
// Optional TIMER_AUTO_RELOAD_EN: final tick reloads the last accepted load value instead of DONE.
module timer_countdown_chain #(
  parameter int unsigned           DIGITS = 4,
  parameter logic [4*DIGITS-1:0]   RADIX  = 16'hAA6A
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  loadn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  zero,
  output logic                  done
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] dec_val;
  logic                load_accept;

  // Per-digit clamp of the load value to radix-1.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] >= RADIX[4*i +: 4]) begin
        load_val[4*i +: 4] = RADIX[4*i +: 4] - 4'd1;
      end else begin
        load_val[4*i +: 4] = data[4*i +: 4];
      end
    end
  end

  // Borrow ripples upward while the lower digits are all zero.
  always_comb begin
    logic brw;
    brw     = 1'b1;
    dec_val = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (brw) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = RADIX[4*i +: 4] - 4'd1;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
        end
      end
      brw = brw & (count_q[4*i +: 4] == 4'd0);
    end
  end

  assign zero        = (count_q == '0);
  assign load_accept = !loadn && (state_q != StRun);

`ifdef TIMER_AUTO_RELOAD_EN
  logic [4*DIGITS-1:0] reload_q, reload_d;

  always_comb begin
    reload_d = reload_q;
    if (load_accept) begin
      reload_d = load_val;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_accept) begin
          count_d = load_val;
        end else if (stop) begin
          count_d = '0;
        end else if (start && !zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Load is ignored here; start has nothing to do, so a tick still proceeds.
        if (stop) begin
          state_d = StPause;
        end else if (en && !zero) begin
          count_d = dec_val;
          if (dec_val == '0) begin
            done_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              count_d = reload_q;
            end else begin
              state_d = StDone;
            end
`else
            state_d = StDone;
`endif
          end
        end
      end
      StPause: begin
        if (load_accept) begin
          count_d = load_val;
          state_d = StIdle;
        end else if (stop) begin
          count_d = '0;
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
        end
      end
      StDone: begin
        count_d = '0;
        if (load_accept) begin
          count_d = load_val;
          state_d = StIdle;
        end else if (stop) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timer_countdown_chain.sv
// Directed, table-driven bench for timer_countdown_chain (default MM:SS radices).
module tb_timer_countdown_chain;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] data = 16'h0;
  logic        loadn = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        en = 1'b0;
  logic [15:0] count;
  logic [1:0]  state;
  logic        zero;
  logic        done;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SP = 2'b10;
  localparam logic [1:0] SD = 2'b11;

  timer_countdown_chain dut (
    .clk   (clk),
    .clr   (clr),
    .data  (data),
    .loadn (loadn),
    .start (start),
    .stop  (stop),
    .en    (en),
    .count (count),
    .state (state),
    .zero  (zero),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        loadn;
    logic        start;
    logic        stop;
    logic        en;
    logic [15:0] data;
    logic [15:0] ecount;
    logic [1:0]  estate;
    logic        edone;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input string name, input logic ld_n, input logic st, input logic sp,
                              input logic e, input logic [15:0] d, input logic [15:0] ec,
                              input logic [1:0] es, input logic ed);
    vec_t v;
    v.name = name; v.loadn = ld_n; v.start = st; v.stop = sp; v.en = e; v.data = d;
    v.ecount = ec; v.estate = es; v.edone = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] ec, input logic [1:0] es,
                       input logic ed);
    logic ez;
    ez = (ec == 16'h0);
    n_vec++;
    if (count !== ec || state !== es || zero !== ez || done !== ed) begin
      n_err++;
      $display("FAIL %s: got count=%h state=%0d zero=%b done=%b, want count=%h state=%0d zero=%b done=%b",
               name, count, state, zero, done, ec, es, ez, ed);
    end
  endtask

  task automatic idle_inputs();
    loadn = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; data = 16'h0;
  endtask

  initial begin
    // name, loadn, start, stop, en, data, exp count, exp state, exp done
    add("ld0100",    0, 0, 0, 0, 16'h0100, 16'h0100, SI, 0);
    add("start0100", 1, 1, 0, 0, 16'h0,    16'h0100, SR, 0);
    add("tick0059",  1, 0, 0, 1, 16'h0,    16'h0059, SR, 0);
    add("pause0059", 1, 0, 1, 0, 16'h0,    16'h0059, SP, 0);
    add("cancel1",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("ldclamp",   0, 0, 0, 0, 16'hFF9F, 16'h9959, SI, 0);
    add("startclmp", 1, 1, 0, 0, 16'h0,    16'h9959, SR, 0);
    add("tick9958",  1, 0, 0, 1, 16'h0,    16'h9958, SR, 0);
    add("tick9957",  1, 0, 0, 1, 16'h0,    16'h9957, SR, 0);
    add("tick9956",  1, 0, 0, 1, 16'h0,    16'h9956, SR, 0);
    add("pause9956", 1, 0, 1, 0, 16'h0,    16'h9956, SP, 0);
    add("cancel2",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("ld0130",    0, 0, 0, 0, 16'h0130, 16'h0130, SI, 0);
    add("start0130", 1, 1, 0, 0, 16'h0,    16'h0130, SR, 0);
    add("tick0129",  1, 0, 0, 1, 16'h0,    16'h0129, SR, 0);
    add("tick0128",  1, 0, 0, 1, 16'h0,    16'h0128, SR, 0);
    add("pause0128", 1, 0, 1, 0, 16'h0,    16'h0128, SP, 0);
    for (int i = 0; i < 5; i++) add("pause_en", 1, 0, 0, 1, 16'h0, 16'h0128, SP, 0);
    add("resume",    1, 1, 0, 0, 16'h0,    16'h0128, SR, 0);
    add("tick0127",  1, 0, 0, 1, 16'h0,    16'h0127, SR, 0);
    add("pause0127", 1, 0, 1, 0, 16'h0,    16'h0127, SP, 0);
    add("cancel3",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("ld0010",    0, 0, 0, 0, 16'h0010, 16'h0010, SI, 0);
    add("startstop", 1, 1, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("ld0010b",   0, 0, 0, 0, 16'h0010, 16'h0010, SI, 0);
    add("start0010", 1, 1, 0, 0, 16'h0,    16'h0010, SR, 0);
    add("ldinrun",   0, 0, 0, 0, 16'h0005, 16'h0010, SR, 0);
    add("tick0009",  1, 0, 0, 1, 16'h0,    16'h0009, SR, 0);
    add("pause0009", 1, 0, 1, 0, 16'h0,    16'h0009, SP, 0);
    add("cancel4",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("startzero", 1, 1, 0, 0, 16'h0,    16'h0000, SI, 0);
    add("ld0001",    0, 0, 0, 0, 16'h0001, 16'h0001, SI, 0);
    add("start0001", 1, 1, 0, 0, 16'h0,    16'h0001, SR, 0);
    add("stopfinal", 1, 0, 1, 1, 16'h0,    16'h0001, SP, 0);
    add("cancel5",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("ldstart",   0, 1, 0, 0, 16'h0020, 16'h0020, SI, 0);
    add("clear_idl", 1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("ld0001b",   0, 0, 0, 0, 16'h0001, 16'h0001, SI, 0);
    add("start01b",  1, 1, 0, 0, 16'h0,    16'h0001, SR, 0);
`ifdef TIMER_AUTO_RELOAD_EN
    add("final_rl",  1, 0, 0, 1, 16'h0,    16'h0001, SR, 1);
    add("final_rl2", 1, 0, 0, 1, 16'h0,    16'h0001, SR, 1);
    add("start_rl",  1, 1, 0, 0, 16'h0,    16'h0001, SR, 0);
    add("pause_rl",  1, 0, 1, 0, 16'h0,    16'h0001, SP, 0);
    add("cancel_rl", 1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
`else
    add("final",     1, 0, 0, 1, 16'h0,    16'h0000, SD, 1);
    add("done_hold", 1, 0, 0, 1, 16'h0,    16'h0000, SD, 0);
    add("start_dn",  1, 1, 0, 0, 16'h0,    16'h0000, SD, 0);
    add("stop_dn",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);
    add("idle_hold", 1, 0, 0, 1, 16'h0,    16'h0000, SI, 0);
`endif
    add("ld0002",    0, 0, 0, 0, 16'h0002, 16'h0002, SI, 0);
    add("start0002", 1, 1, 0, 0, 16'h0,    16'h0002, SR, 0);
    add("tick0001",  1, 0, 0, 1, 16'h0,    16'h0001, SR, 0);
`ifdef TIMER_AUTO_RELOAD_EN
    add("reload",    1, 0, 0, 1, 16'h0,    16'h0002, SR, 1);
    add("reload_nd", 1, 0, 0, 0, 16'h0,    16'h0002, SR, 0);
    add("pause_r2",  1, 0, 1, 0, 16'h0,    16'h0002, SP, 0);
`else
    add("final2",    1, 0, 0, 1, 16'h0,    16'h0000, SD, 1);
    add("done_nd",   1, 0, 0, 0, 16'h0,    16'h0000, SD, 0);
    add("ld_in_dn",  0, 0, 0, 0, 16'h0003, 16'h0003, SI, 0);
`endif
    add("cancel6",   1, 0, 1, 0, 16'h0,    16'h0000, SI, 0);

    // Asynchronous reset with no clock edge.
    #2 clr = 1'b1;
    #1 check("reset", 16'h0000, SI, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      loadn = vecs[k].loadn; start = vecs[k].start; stop = vecs[k].stop;
      en = vecs[k].en; data = vecs[k].data;
      @(posedge clk);
      #1 check(vecs[k].name, vecs[k].ecount, vecs[k].estate, vecs[k].edone);
    end

    // clr pulsed between edges while running.
    @(negedge clk);
    loadn = 1'b0; data = 16'h0100;
    @(negedge clk);
    idle_inputs(); start = 1'b1;
    @(negedge clk);
    idle_inputs(); en = 1'b1;
    @(posedge clk);
    #1 check("pre_clr", 16'h0059, SR, 1'b0);
    #2 clr = 1'b1;
    #1 check("mid_clr", 16'h0000, SI, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1 check("post_clr", 16'h0000, SI, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
